// File: rtl/zxuno_ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package zxuno_ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0]  PS2_PREFIX_EXT     = 8'hE0;
   localparam logic [7:0]  PS2_PREFIX_REL     = 8'hF0;
   localparam int unsigned PS2_FILTER_LEN_DEF = 8;
   localparam int unsigned PS2_TIMEOUT_DEF    = 28000;

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser plus hold filter: level changes only after FILTER_LEN equal samples.
module ps2_line_filter
   import zxuno_ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN = PS2_FILTER_LEN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic line_i,
   output logic level_o,
   output logic fall_o
);

   logic [1:0]            sync_q, sync_d;
   logic [FILTER_LEN-1:0] taps_q, taps_d;
   logic                  level_q, level_d;
   logic                  level_prev_q, level_prev_d;

   always_comb begin
      sync_d       = {sync_q[0], line_i};
      taps_d       = {taps_q[FILTER_LEN-2:0], sync_q[1]};
      level_prev_d = level_q;
      level_d      = level_q;
      if (&taps_q)
         level_d = 1'b1;
      else if (~|taps_q)
         level_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q       <= '1;
         taps_q       <= '1;
         level_q      <= 1'b1;
         level_prev_q <= 1'b1;
      end else begin
         sync_q       <= sync_d;
         taps_q       <= taps_d;
         level_q      <= level_d;
         level_prev_q <= level_prev_d;
      end
   end

   assign level_o = level_q;
   assign fall_o  = level_prev_q & ~level_q;

endmodule

// File: rtl/ps2_keyb_rx.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix decoding.
// Optional watchdog abort of stalled frames: define PS2_RX_TIMEOUT_EN.
module ps2_keyb_rx
   import zxuno_ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = PS2_FILTER_LEN_DEF,
   parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clkps2,
   input  logic       dataps2,
   output logic [7:0] scancode,
   output logic       extended,
   output logic       released,
   output logic       code_valid,
   output logic       frame_err
);

   logic       fall;
   logic       clk_level_unused;
   logic [1:0] dsync_q, dsync_d;
   logic       data_bit;

   ps2_state_e state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       par_q, par_d;
   logic [7:0] code_q, code_d;
   logic       ext_q, ext_d, rel_q, rel_d;
   logic       ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d;
   logic       valid_q, valid_d, err_q, err_d;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk     (clk),
      .rst     (rst),
      .line_i  (clkps2),
      .level_o (clk_level_unused),
      .fall_o  (fall)
   );

   // Data needs no filter: it is stable long before the filtered clock edge arrives.
   assign dsync_d  = {dsync_q[0], dataps2};
   assign data_bit = dsync_q[1];

`ifdef PS2_RX_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
`else
   logic unused_timeout;
   assign unused_timeout = TIMEOUT_CYCLES[0];
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      code_d     = code_q;
      ext_d      = ext_q;
      rel_d      = rel_q;
      ext_pend_d = ext_pend_q;
      rel_pend_d = rel_pend_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      if (fall) begin
         case (state_q)
            ST_IDLE: if (!data_bit) begin
               state_d = ST_DATA;
               cnt_d   = 3'd0;
               shift_d = 8'h00;
            end
            ST_DATA: begin
               shift_d = {data_bit, shift_q[7:1]};
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7)
                  state_d = ST_PARITY;
            end
            ST_PARITY: begin
               par_d   = data_bit;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if ((^shift_q ^ par_q) && data_bit) begin
                  if (shift_q == PS2_PREFIX_EXT)
                     ext_pend_d = 1'b1;
                  else if (shift_q == PS2_PREFIX_REL)
                     rel_pend_d = 1'b1;
                  else begin
                     code_d     = shift_q;
                     ext_d      = ext_pend_q;
                     rel_d      = rel_pend_q;
                     valid_d    = 1'b1;
                     ext_pend_d = 1'b0;
                     rel_pend_d = 1'b0;
                  end
               end else begin
                  err_d      = 1'b1;
                  ext_pend_d = 1'b0;
                  rel_pend_d = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
`ifdef PS2_RX_TIMEOUT_EN
      wd_d = (state_q == ST_IDLE || fall) ? '0 : wd_q + 1'b1;
      if (state_q != ST_IDLE && !fall && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
         state_d    = ST_IDLE;
         err_d      = 1'b1;
         ext_pend_d = 1'b0;
         rel_pend_d = 1'b0;
         wd_d       = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dsync_q    <= '1;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         code_q     <= 8'h00;
         ext_q      <= 1'b0;
         rel_q      <= 1'b0;
         ext_pend_q <= 1'b0;
         rel_pend_q <= 1'b0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         dsync_q    <= dsync_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         code_q     <= code_d;
         ext_q      <= ext_d;
         rel_q      <= rel_d;
         ext_pend_q <= ext_pend_d;
         rel_pend_q <= rel_pend_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

`ifdef PS2_RX_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) wd_q <= '0;
      else     wd_q <= wd_d;
   end
`endif

   assign scancode   = code_q;
   assign extended   = ext_q;
   assign released   = rel_q;
   assign code_valid = valid_q;
   assign frame_err  = err_q;

endmodule
